// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit, 4-register pipeline CPU: opcodes,
// instruction field slices and the fetch-unit state encoding.
package cpu_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_JMP  = 2'b11;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   function automatic logic [1:0] opcode(input logic [7:0] instr);
      return instr[7:6];
   endfunction

   function automatic logic [1:0] rd(input logic [7:0] instr);
      return instr[5:4];
   endfunction

   function automatic logic [1:0] rs1(input logic [7:0] instr);
      return instr[3:2];
   endfunction

   function automatic logic [1:0] rs2(input logic [7:0] instr);
      return instr[1:0];
   endfunction

   function automatic logic [3:0] jmp_tgt(input logic [7:0] instr);
      return instr[3:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head, push-while-full when a
// pop happens on the same edge, and a flush that overrides push and pop.
module sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign dout  = mem_q[rd_ptr_q];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (do_push && !do_pop)      level_d = level_q + LW'(1);
         else if (do_pop && !do_push) level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is data only; validity is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction-fetch front end: programmable instruction memory, PC with local
// absolute-jump resolution, and a prefetch FIFO toward decode.
module pipe_fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      prog_we,
   input  logic [ADDR_W-1:0]         prog_addr,
   input  logic [DATA_W-1:0]         prog_data,
   input  logic                      start,
   input  logic                      stop,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_instr,
   output logic [ADDR_W-1:0]         out_pc,
   output logic                      running,
   output logic [$clog2(DEPTH):0]    fifo_level
);

   localparam int FW = ADDR_W + DATA_W;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] imem_q [2**ADDR_W];

   logic [DATA_W-1:0] fetch_instr;
   logic              fetch_is_jmp;
   logic              fifo_push, fifo_pop, fifo_flush;
   logic              fifo_full, fifo_empty;
   logic [FW-1:0]     fifo_dout;
   logic              fetch_room;

   assign fetch_instr  = imem_q[pc_q];
   assign fetch_is_jmp = (opcode(fetch_instr) == OP_JMP);
   assign fifo_pop     = out_valid && out_ready;
   // A slot frees up on the same edge the head is consumed.
   assign fetch_room   = !fifo_full || fifo_pop;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      case (state_q)
         LOAD: begin
            if (start && !stop) begin
               state_d = RUN;
               pc_d    = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d    = LOAD;
               pc_d       = '0;
               fifo_flush = 1'b1;
            end else if (fetch_room) begin
               if (fetch_is_jmp) begin
                  pc_d = ADDR_W'(jmp_tgt(fetch_instr));
               end else begin
                  fifo_push = 1'b1;
                  pc_d      = pc_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LOAD;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Memory survives reset; it is only writable while loading.
   always_ff @(posedge clk) begin
      if (rst_n && state_q == LOAD && prog_we) imem_q[prog_addr] <= prog_data;
   end

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   ({pc_q, fetch_instr}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign out_valid = !fifo_empty;
   assign out_instr = out_valid ? fifo_dout[DATA_W-1:0] : '0;
   assign out_pc    = out_valid ? fifo_dout[FW-1:DATA_W] : '0;
   assign running   = (state_q == RUN);

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit with a program-order scoreboard built
// from a private copy of the instruction memory.
module tb_pipe_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic       start, stop;
   logic       out_valid, out_ready;
   logic [7:0] out_instr;
   logic [3:0] out_pc;
   logic       running;
   logic [1:0] fifo_level;

   int total = 0;
   int bad   = 0;
   logic [7:0]  mem_m [16];
   logic [11:0] exp_q [$];
   int bubbles;
   bit seen_valid;

   always #5 clk = ~clk;

   pipe_fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .start      (start),
      .stop       (stop),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .running    (running),
      .fifo_level (fifo_level)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected push order from PC=0, skipping JMPs exactly as the fetch unit should.
   task automatic build_expect(input int n);
      logic [3:0] pc;
      int guard;
      exp_q.delete();
      pc = 4'd0;
      guard = 0;
      while (exp_q.size() < n && guard < 500) begin
         if (mem_m[pc][7:6] == 2'b11) pc = mem_m[pc][3:0];
         else begin
            exp_q.push_back({pc, mem_m[pc]});
            pc = pc + 4'd1;
         end
         guard++;
      end
   endtask

   // One clock: sample at the falling edge, then advance to just past the rising edge.
   task automatic cyc();
      logic [11:0] e;
      @(negedge clk);
      if (seen_valid && !out_valid) bubbles++;
      if (out_valid) seen_valid = 1'b1;
      if (out_valid && out_ready && rst_n && !stop) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            $display("pop pc=%0d instr=%02h exp_pc=%0d exp_instr=%02h", out_pc, out_instr, e[11:8], e[7:0]);
            chk("pop_pc", 32'(out_pc), 32'(e[11:8]));
            chk("pop_instr", 32'(out_instr), 32'(e[7:0]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input logic [3:0] a, input logic [7:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      cyc();
      prog_we = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic do_start();
      build_expect(60);
      seen_valid = 1'b0;
      bubbles = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      start = 1'b0; stop = 1'b0; out_ready = 1'b0;
      bubbles = 0; seen_valid = 1'b0;
      cyc(); cyc();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_instr", 32'(out_instr), 32'd0);
      chk("rst_pc", 32'(out_pc), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      rst_n = 1'b1;
      cyc();

      // 1: straight-line code with wrap
      prog(4'd0, 8'h16); prog(4'd1, 8'h25); prog(4'd2, 8'h8E);
      prog(4'd3, 8'h13); prog(4'd4, 8'h00);
      for (int i = 5; i < 16; i++) prog(4'(i), 8'(8'h40 + i));
      out_ready = 1'b1;
      do_start();
      chk("t1_running", 32'(running), 32'd1);
      chk("t1_valid_e0", 32'(out_valid), 32'd0);
      cyc();
      chk("t1_valid_e1", 32'(out_valid), 32'd1);
      chk("t1_first_pc", 32'(out_pc), 32'd0);
      for (int i = 0; i < 20; i++) cyc();
      chk("t1_bubbles", 32'(bubbles), 32'd0);
      out_ready = 1'b0;
      do_stop();

      // 2: jump costs one bubble, JMP never delivered
      prog(4'd2, 8'hC7); prog(4'd7, 8'h11);
      out_ready = 1'b1;
      do_start();
      for (int i = 0; i < 10; i++) cyc();
      chk("t2_bubbles", 32'(bubbles), 32'd1);
      out_ready = 1'b0;
      do_stop();
      prog(4'd2, 8'h8E); prog(4'd7, 8'h47);

      // 3: backpressure
      do_start();
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (i > 0) chk("t3_head_instr", 32'(out_instr), 32'(mem_m[0]));
      end
      chk("t3_level", 32'(fifo_level), 32'd2);
      chk("t3_head_pc", 32'(out_pc), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) cyc();

      // 4: full with simultaneous push/pop
      out_ready = 1'b0;
      cyc(); cyc();
      chk("t4_full", 32'(fifo_level), 32'd2);
      out_ready = 1'b1; cyc(); chk("t4_lvl_a", 32'(fifo_level), 32'd2);
      out_ready = 1'b0; cyc(); chk("t4_lvl_b", 32'(fifo_level), 32'd2);
      out_ready = 1'b1; cyc(); chk("t4_lvl_c", 32'(fifo_level), 32'd2);
      cyc(); chk("t4_lvl_d", 32'(fifo_level), 32'd2);

      // 5: writes ignored in RUN, stop while full
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hFF;
      cyc();
      prog_we = 1'b0;
      out_ready = 1'b0;
      cyc(); cyc();
      chk("t5_full", 32'(fifo_level), 32'd2);
      do_stop();
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_level", 32'(fifo_level), 32'd0);
      chk("t5_running", 32'(running), 32'd0);
      do_start();
      cyc();
      chk("t5_restart_pc", 32'(out_pc), 32'd0);
      chk("t5_imem0", 32'(out_instr), 32'h16);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();

      // 6: reset mid-run
      rst_n = 1'b0;
      cyc();
      exp_q.delete();
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_instr", 32'(out_instr), 32'd0);
      chk("t6_pc", 32'(out_pc), 32'd0);
      chk("t6_running", 32'(running), 32'd0);
      chk("t6_level", 32'(fifo_level), 32'd0);
      rst_n = 1'b1;
      cyc();
      chk("t6_still_load", 32'(running), 32'd0);
      do_start();
      cyc();
      chk("t6_first_pc", 32'(out_pc), 32'd0);
      chk("t6_first_instr", 32'(out_instr), 32'h16);
      for (int i = 0; i < 6; i++) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
